// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, logical/arithmetic shifts, rotates,
// parallel load and clear, with a saturating count of serial shifts since the last load.
module universal_shift_register #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             drained_q, drained_d;
  logic             cnt_inc;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    q_d     = q_q;
    cnt_d   = cnt_q;
    cnt_inc = 1'b0;

    if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: q_d = q_q;
        MODE_SHR: begin
          q_d     = {sin_r, q_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], sin_l};
          cnt_inc = 1'b1;
        end
        MODE_ROR: q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        MODE_ASR: begin
          q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: q_d = q_q;
      endcase
    end

    // Data keeps moving past WIDTH shifts; only the count stops.
    if (cnt_inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end

    drained_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
    if (rst) begin
      q_q       <= '0;
      cnt_q     <= '0;
      drained_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      drained_q <= drained_d;
    end
  end

  assign q         = q_q;
  assign shift_cnt = cnt_q;
  assign drained   = drained_q;
  assign sout_r    = q_q[0];
  assign sout_l    = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8): table of single-edge vectors
// followed by hand-written serial-drain and reset-mid-shift sequences.
module tb_universal_shift_register;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    shift_cnt;
  logic             drained;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .drained   (drained)
  );

  typedef struct {
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] exp_q;
    int               exp_cnt;
    logic             exp_drained;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [2:0] m, input logic [WIDTH-1:0] dd,
                     input logic sr, input logic sl, input logic [WIDTH-1:0] eq, input int ec,
                     input logic ed);
    vec_t v;
    v = '{r, e, m, dd, sr, sl, eq, ec, ed};
    vecs.push_back(v);
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m, input logic [WIDTH-1:0] dd,
                      input logic sr, input logic sl);
    @(negedge clk);
    rst = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] eq, input int ec,
                             input logic ed);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".cnt"}, 32'(shift_cnt), 32'(ec));
    check({tag, ".drained"}, 32'(drained), 32'(ed));
  endtask

  initial begin
    logic [WIDTH-1:0] exp_q;
    logic [7:0]       drain_bits;

    rst = 1'b1; en = 1'b0; mode = M_HOLD; d = '0; sin_r = 1'b0; sin_l = 1'b0;

    // Reset with a pending LOAD, then release.
    add(1, 1, M_LOAD, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(1, 1, M_LOAD, 8'hA5, 0, 0, 8'h00, 0, 0);
    add(0, 1, M_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0);
    add(0, 1, M_HOLD, 8'h00, 1, 1, 8'hA5, 0, 0);
    // Logical shifts.
    add(0, 1, M_SHR,  8'h00, 1, 0, 8'hD2, 1, 0);
    add(0, 1, M_SHR,  8'h00, 1, 0, 8'hE9, 2, 0);
    add(0, 1, M_SHR,  8'h00, 1, 0, 8'hF4, 3, 0);
    add(0, 1, M_SHL,  8'h00, 1, 0, 8'hE8, 4, 0);
    add(0, 1, M_SHL,  8'h00, 1, 0, 8'hD0, 5, 0);
    // Rotates leave the count alone; 8 RORs restore the value.
    add(0, 1, M_LOAD, 8'h81, 0, 0, 8'h81, 0, 0);
    add(0, 1, M_ROL,  8'h00, 0, 0, 8'h03, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h81, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'hC0, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h60, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h30, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h18, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h0C, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h06, 0, 0);
    add(0, 1, M_ROR,  8'h00, 0, 0, 8'h03, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, M_SHR, 8'hFF, 1, 1, 8'h03, 0, 0);
    // ASR of a negative value with sin_r=0, saturating count.
    add(0, 1, M_LOAD, 8'h90, 0, 0, 8'h90, 0, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hC8, 1, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hE4, 2, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hF2, 3, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hF9, 4, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hFC, 5, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hFE, 6, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hFF, 7, 0);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hFF, 8, 1);
    add(0, 1, M_ASR,  8'h00, 0, 0, 8'hFF, 8, 1);
    add(0, 0, M_CLR,  8'h00, 0, 0, 8'hFF, 8, 1);
    add(0, 1, M_CLR,  8'h00, 0, 0, 8'h00, 0, 0);
    // ASR of a non-negative value ignores sin_r=1.
    add(0, 1, M_LOAD, 8'h40, 0, 0, 8'h40, 0, 0);
    add(0, 1, M_ASR,  8'h00, 1, 0, 8'h20, 1, 0);
    add(0, 1, M_SHL,  8'h00, 0, 1, 8'h41, 2, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin_r, vecs[i].sin_l);
      check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_drained);
      exp_q = vecs[i].exp_q;
      check($sformatf("vec%0d.sout_r", i), 32'(sout_r), 32'(exp_q[0]));
      check($sformatf("vec%0d.sout_l", i), 32'(sout_l), 32'(exp_q[WIDTH-1]));
    end

    // Serial drain of 8'h3C, LSB first, sampling sout_r before each shift edge.
    drain_bits = 8'h3C;
    step(0, 1, M_LOAD, 8'h3C, 0, 0);
    check_state("drain.load", 8'h3C, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("drain.bit%0d", i), 32'(sout_r), 32'(drain_bits[i]));
      rst = 1'b0; en = 1'b1; mode = M_SHR; sin_r = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("drain.cnt%0d", i), 32'(shift_cnt), 32'(i + 1));
      check($sformatf("drain.drained%0d", i), 32'(drained), 32'(i == 7));
    end
    check_state("drain.end", 8'h00, 8, 1);

    // Reset in the middle of an SHL run.
    step(0, 1, M_CLR, 8'h00, 0, 0);
    step(0, 1, M_SHL, 8'h00, 0, 1);
    step(0, 1, M_SHL, 8'h00, 0, 1);
    step(0, 1, M_SHL, 8'h00, 0, 1);
    step(0, 1, M_SHL, 8'h00, 0, 1);
    check_state("rstmid.pre", 8'h0F, 4, 0);
    step(1, 1, M_SHL, 8'h00, 0, 1);
    check_state("rstmid.rst", 8'h00, 0, 0);
    step(0, 1, M_SHL, 8'h00, 0, 1);
    check_state("rstmid.post", 8'h01, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
